stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Front-end controller that sits directly upstream of the stopwatch counter. It conditions three raw push-buttons (synchronise, debounce, rising-edge detect) and runs a run/pause/clear state machine. From that it drives the counter's Start_S, Stop_S, Reset_S and Control inputs. It runs on the same 1 ms tick clock as the counter.

Parameters:
DEB_MS, 20, consecutive stable samples (ms) required before a debounced level changes; legal range 2..255
CLR_CYCLES, 2, cycles Stop_S/Reset_S stay asserted in CLEAR; legal range 1..15
SYNC_STAGES, 2, synchroniser flops per raw button; legal range 2..3

Ports:
Clock_1MSec  input  1  1 kHz system clock; all state on posedge
Reset  input  1  asynchronous, active-high reset
Btn_StartStop  input  1  raw start/stop button, asynchronous, active-high
Btn_Clear  input  1  raw clear button, asynchronous, active-high
Btn_Mode  input  1  raw mode button, asynchronous, active-high
Start_S  output  1  1 = counter counts (RUN)
Stop_S  output  1  1 = counter clears (CLEAR)
Reset_S  output  1  clear strobe, identical timing to Stop_S
Control  output  1  0 = stopwatch mode, 1 = clock mode

Behaviour:
- Clocking: one clock, Clock_1MSec. Reset is asynchronous and active-high.
- Reset values: all outputs 0; FSM = IDLE; debounced levels 0; counters 0.
- Button path, per button:
  - SYNC_STAGES-flop synchroniser.
  - Debounce counter: while the synchronised value differs from the debounced level, count up; at DEB_MS-1, flip the level and zero the counter. Any sample equal to the level zeroes the counter.
  - Press pulse: one cycle, on the debounced 0->1 edge.
  - Latency raw->pulse = SYNC_STAGES + DEB_MS cycles. Glitches shorter than DEB_MS are ignored.
- FSM states: IDLE, RUN, PAUSE, CLEAR.
  - IDLE: Start_S=0, Stop_S=0. ss_pulse -> RUN.
  - RUN: Start_S=1. ss_pulse -> PAUSE.
  - PAUSE: Start_S=0, Stop_S=0. ss_pulse -> RUN.
  - CLEAR: Start_S=0, Stop_S=1, Reset_S=1 for exactly CLR_CYCLES cycles, then -> IDLE.
  - clr_pulse from any state -> CLEAR, and reloads the CLEAR cycle counter.
- Simultaneous events:
  - clr_pulse beats ss_pulse.
  - ss_pulse while in CLEAR is dropped.
  - mode_pulse is independent of the FSM and can coincide with either of the others.
- Control:
  - Toggles on each mode_pulse in any state; the FSM state is preserved.
  - While Control=1, the FSM still runs and outputs are still driven. The counter ignores them.
- Outputs are registered. Start_S/Stop_S change one cycle after the pulse.
- Stop_S and Start_S are never both 1.
- Reset mid-CLEAR: outputs to 0 immediately, FSM -> IDLE.

Optional Feature:
STOPWATCH_CTRL_LAP_EN:
- Defined:
  - Adds input Btn_Lap (raw, active-high) and output Lap_Hold (1 bit, reset 0).
  - A debounced lap press in RUN toggles Lap_Hold.
  - Lap_Hold forced to 0 on entering PAUSE, CLEAR or IDLE.
  - Lap presses outside RUN are ignored.
- Undefined: the port and logic are absent; the other ports and behaviour are unchanged.

Decomposition:
- Package stopwatch_pkg:
  - FSM state type with encodings IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, CLEAR=2'd3.
  - Constants CTRL_STOPWATCH=1'b0, CTRL_CLOCK=1'b1.
- Sub-module btn_debounce:
  - Parameters SYNC_STAGES, DEB_MS; ports Clock_1MSec, Reset, btn_raw, level, press.
  - Instantiated three times, four with STOPWATCH_CTRL_LAP_EN.

Test Plan:
- Reset then idle 100 cycles -> all outputs 0.
- Btn_StartStop high 30 cycles -> Start_S=1 from cycle 23 (SYNC 2 + DEB 20 + 1 registered). A second press -> Start_S=0, Stop_S=0.
- Bounce: Btn_StartStop toggles every 5 cycles for 60 cycles, then held low -> Start_S stays 0 throughout.
- In RUN, Btn_Clear held 30 cycles -> Start_S=0, Stop_S=Reset_S=1 for exactly 2 cycles, then IDLE. Btn_StartStop and Btn_Clear released into debounce together -> clear wins.
- Btn_Mode pressed while RUN -> Control 0->1, Start_S remains 1. Second press -> Control=0.
- Reset asserted in the 1st CLEAR cycle -> Stop_S, Reset_S, Control drop to 0 asynchronously, FSM=IDLE. With STOPWATCH_CTRL_LAP_EN: lap press in RUN -> Lap_Hold=1; then pause -> Lap_Hold=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and mode constants for the stopwatch front-end
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        CLEAR = 2'd3
    } sw_state_e;

    localparam logic CTRL_STOPWATCH = 1'b0;
    localparam logic CTRL_CLOCK     = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - raw button synchroniser, counting debouncer and press-edge pulse
module btn_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_MS      = 20
) (
    input  logic Clock_1MSec,
    input  logic Reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam logic [7:0] CNT_MAX = 8'(DEB_MS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [7:0]             cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // press is registered alongside the level flip, so it lands SYNC_STAGES+DEB_MS cycles after the raw edge
    always_ff @(posedge Clock_1MSec or posedge Reset) begin
        if (Reset) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            press  <= 1'b0;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= synced;
                press <= synced;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - button conditioning and run/pause/clear FSM; STOPWATCH_CTRL_LAP_EN adds lap hold
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEB_MS      = 20,
    parameter int CLR_CYCLES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock_1MSec,
    input  logic Reset,
    input  logic Btn_StartStop,
    input  logic Btn_Clear,
    input  logic Btn_Mode,
`ifdef STOPWATCH_CTRL_LAP_EN
    input  logic Btn_Lap,
    output logic Lap_Hold,
`endif
    output logic Start_S,
    output logic Stop_S,
    output logic Reset_S,
    output logic Control
);

    localparam logic [3:0] CLR_LOAD = 4'(CLR_CYCLES - 1);

    sw_state_e  state, next_state;
    logic [3:0] clr_cnt, clr_cnt_next;
    logic       ss_pulse, clr_pulse, mode_pulse;
    logic [2:0] levels_unused;

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_MS(DEB_MS)) u_deb_ss (
        .Clock_1MSec(Clock_1MSec), .Reset(Reset), .btn_raw(Btn_StartStop),
        .level(levels_unused[0]), .press(ss_pulse)
    );

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_MS(DEB_MS)) u_deb_clr (
        .Clock_1MSec(Clock_1MSec), .Reset(Reset), .btn_raw(Btn_Clear),
        .level(levels_unused[1]), .press(clr_pulse)
    );

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_MS(DEB_MS)) u_deb_mode (
        .Clock_1MSec(Clock_1MSec), .Reset(Reset), .btn_raw(Btn_Mode),
        .level(levels_unused[2]), .press(mode_pulse)
    );

`ifdef STOPWATCH_CTRL_LAP_EN
    logic lap_pulse;
    logic lap_level_unused;

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_MS(DEB_MS)) u_deb_lap (
        .Clock_1MSec(Clock_1MSec), .Reset(Reset), .btn_raw(Btn_Lap),
        .level(lap_level_unused), .press(lap_pulse)
    );
`endif

    // clear overrides everything, including a start/stop press in the same cycle
    always_comb begin
        next_state   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            IDLE, PAUSE: if (ss_pulse) next_state = RUN;
            RUN:         if (ss_pulse) next_state = PAUSE;
            CLEAR: begin
                if (clr_cnt == 4'd0) next_state = IDLE;
                else                 clr_cnt_next = clr_cnt - 4'd1;
            end
            default:     next_state = IDLE;
        endcase
        if (clr_pulse) begin
            next_state   = CLEAR;
            clr_cnt_next = CLR_LOAD;
        end
    end

    // outputs decode next_state so they are registered with the state itself
    always_ff @(posedge Clock_1MSec or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            clr_cnt <= '0;
            Start_S <= 1'b0;
            Stop_S  <= 1'b0;
            Reset_S <= 1'b0;
            Control <= CTRL_STOPWATCH;
        end else begin
            state   <= next_state;
            clr_cnt <= clr_cnt_next;
            Start_S <= (next_state == RUN);
            Stop_S  <= (next_state == CLEAR);
            Reset_S <= (next_state == CLEAR);
            if (mode_pulse)
                Control <= (Control == CTRL_CLOCK) ? CTRL_STOPWATCH : CTRL_CLOCK;
        end
    end

`ifdef STOPWATCH_CTRL_LAP_EN
    always_ff @(posedge Clock_1MSec or posedge Reset) begin
        if (Reset)
            Lap_Hold <= 1'b0;
        else if (next_state != RUN)
            Lap_Hold <= 1'b0;
        else if (state == RUN && lap_pulse)
            Lap_Hold <= ~Lap_Hold;
    end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl with directed button vectors
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn_ss = 1'b0, btn_clr = 1'b0, btn_mode = 1'b0;
    logic start_s, stop_s, reset_s, control, lap_act;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

`ifdef STOPWATCH_CTRL_LAP_EN
    logic btn_lap = 1'b0;
    logic lap_hold;
    assign lap_act = lap_hold;
`else
    assign lap_act = 1'b0;
`endif

    stopwatch_ctrl #(.DEB_MS(20), .CLR_CYCLES(2), .SYNC_STAGES(2)) dut (
        .Clock_1MSec(clk),
        .Reset(rst),
        .Btn_StartStop(btn_ss),
        .Btn_Clear(btn_clr),
        .Btn_Mode(btn_mode),
`ifdef STOPWATCH_CTRL_LAP_EN
        .Btn_Lap(btn_lap),
        .Lap_Hold(lap_hold),
`endif
        .Start_S(start_s),
        .Stop_S(stop_s),
        .Reset_S(reset_s),
        .Control(control)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // vector order: {Start_S, Stop_S, Reset_S, Control, Lap_Hold}
    typedef struct {
        int         at;
        logic [4:0] vec;
        string      name;
    } exp_t;

    exp_t q[$];

    task automatic push(input int at, input logic [4:0] vec, input string name);
        exp_t e;
        e.at = at; e.vec = vec; e.name = name;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        logic [4:0] act;
        act = {start_s, stop_s, reset_s, control, lap_act};
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.at != cyc || act !== e.vec) begin
                failures++;
                $display("FAIL %s cyc=%0d want_cyc=%0d got=%b exp=%b", e.name, cyc, e.at, act, e.vec);
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int t;
        rst = 1'b1;
        push(2, 5'b00000, "reset_state");
        wait_cyc(3);
        rst = 1'b0;

        t = cyc;
        push(t + 10, 5'b00000, "idle_10");
        push(t + 50, 5'b00000, "idle_50");
        push(t + 99, 5'b00000, "idle_99");
        wait_cyc(t + 100);
        checks++;
        if ({start_s, stop_s, reset_s, control} !== 4'b0000) begin
            failures++;
            $display("FAIL direct_idle got=%b", {start_s, stop_s, reset_s, control});
        end

        // first start: RUN exactly 23 cycles after the raw edge
        t = cyc; btn_ss = 1'b1;
        push(t + 22, 5'b00000, "ss1_pre");
        push(t + 23, 5'b10000, "ss1_run");
        wait_cyc(t + 30); btn_ss = 1'b0;
        checks++;
        if (start_s !== 1'b1 || stop_s !== 1'b0) begin
            failures++;
            $display("FAIL direct_run start=%b stop=%b", start_s, stop_s);
        end
        push(t + 60, 5'b10000, "ss1_release");
        wait_cyc(t + 75);

        t = cyc; btn_ss = 1'b1;
        push(t + 22, 5'b10000, "ss2_pre");
        push(t + 23, 5'b00000, "ss2_pause");
        wait_cyc(t + 30); btn_ss = 1'b0;
        wait_cyc(t + 75);
        checks++;
        if (start_s !== 1'b0 || stop_s !== 1'b0) begin
            failures++;
            $display("FAIL direct_pause start=%b stop=%b", start_s, stop_s);
        end

        // bounce: 5-cycle runs never satisfy the 20-sample filter
        t = cyc;
        push(t + 20, 5'b00000, "bounce_20");
        push(t + 40, 5'b00000, "bounce_40");
        push(t + 60, 5'b00000, "bounce_60");
        push(t + 85, 5'b00000, "bounce_85");
        for (int i = 0; i < 12; i++) begin
            btn_ss = (i % 2 == 0);
            wait_cyc(t + 5 * (i + 1));
        end
        btn_ss = 1'b0;
        wait_cyc(t + 90);

        t = cyc; btn_ss = 1'b1;
        push(t + 23, 5'b10000, "run2");
        wait_cyc(t + 30); btn_ss = 1'b0;
        wait_cyc(t + 75);

        t = cyc; btn_clr = 1'b1;
        push(t + 22, 5'b10000, "clr_pre");
        push(t + 23, 5'b01100, "clr_c1");
        push(t + 24, 5'b01100, "clr_c2");
        push(t + 25, 5'b00000, "clr_idle");
        wait_cyc(t + 30); btn_clr = 1'b0;
        wait_cyc(t + 75);

        // simultaneous start/stop and clear from IDLE: clear wins
        t = cyc; btn_ss = 1'b1; btn_clr = 1'b1;
        push(t + 22, 5'b00000, "sim_pre");
        push(t + 23, 5'b01100, "sim_c1");
        push(t + 24, 5'b01100, "sim_c2");
        push(t + 25, 5'b00000, "sim_idle");
        push(t + 27, 5'b00000, "sim_idle2");
        wait_cyc(t + 30); btn_ss = 1'b0; btn_clr = 1'b0;
        wait_cyc(t + 75);

        t = cyc; btn_ss = 1'b1;
        push(t + 23, 5'b10000, "run3");
        wait_cyc(t + 30); btn_ss = 1'b0;
        wait_cyc(t + 75);

        t = cyc; btn_mode = 1'b1;
        push(t + 22, 5'b10000, "mode1_pre");
        push(t + 23, 5'b10010, "mode1_clock");
        wait_cyc(t + 30); btn_mode = 1'b0;
        checks++;
        if (control !== 1'b1 || start_s !== 1'b1) begin
            failures++;
            $display("FAIL direct_mode control=%b start=%b", control, start_s);
        end
        wait_cyc(t + 75);

        t = cyc; btn_mode = 1'b1;
        push(t + 22, 5'b10010, "mode2_pre");
        push(t + 23, 5'b10000, "mode2_stopwatch");
        wait_cyc(t + 30); btn_mode = 1'b0;
        wait_cyc(t + 75);

        t = cyc; btn_mode = 1'b1;
        push(t + 23, 5'b10010, "mode3_clock");
        wait_cyc(t + 30); btn_mode = 1'b0;
        wait_cyc(t + 75);

        // reset lands 1 ns into the first CLEAR cycle; outputs must drop before the next edge
        t = cyc; btn_clr = 1'b1;
        push(t + 22, 5'b10010, "rstclr_pre");
        push(t + 23, 5'b00000, "rstclr_async");
        wait_cyc(t + 23); rst = 1'b1;
        wait_cyc(t + 24); btn_clr = 1'b0;
        push(t + 25, 5'b00000, "rstclr_held");
        push(t + 28, 5'b00000, "rstclr_after");
        wait_cyc(t + 26); rst = 1'b0;
        wait_cyc(t + 60);

        t = cyc; btn_ss = 1'b1;
        push(t + 22, 5'b00000, "run4_pre");
        push(t + 23, 5'b10000, "run4_from_idle");
        wait_cyc(t + 30); btn_ss = 1'b0;
        wait_cyc(t + 75);

`ifdef STOPWATCH_CTRL_LAP_EN
        t = cyc; btn_lap = 1'b1;
        push(t + 22, 5'b10000, "lap_pre");
        push(t + 23, 5'b10001, "lap_hold");
        wait_cyc(t + 30); btn_lap = 1'b0;
        wait_cyc(t + 75);

        t = cyc; btn_ss = 1'b1;
        push(t + 22, 5'b10001, "lap_pause_pre");
        push(t + 23, 5'b00000, "lap_pause");
        wait_cyc(t + 30); btn_ss = 1'b0;
        wait_cyc(t + 75);

        t = cyc; btn_lap = 1'b1;
        push(t + 23, 5'b00000, "lap_ignored");
        wait_cyc(t + 30); btn_lap = 1'b0;
        wait_cyc(t + 75);
`else
        t = cyc; btn_ss = 1'b1;
        push(t + 22, 5'b10000, "final_pause_pre");
        push(t + 23, 5'b00000, "final_pause");
        wait_cyc(t + 30); btn_ss = 1'b0;
        wait_cyc(t + 75);
`endif

        wait_cyc(cyc + 5);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s never_checked want_cyc=%0d exp=%b", e.name, e.at, e.vec);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
